sdfilter_ctrl: RTL

Measurement sequencer for the sdfilter coincidence chain. It programs the filter's gate0/gaten masks, holds the filter in reset while the masks change, and waits for the delay lines to settle. It then counts event pulses on one selected filter output over a programmable window and hands the count to the readout logic (ESP32 interface) through a valid/ack handshake. Sits between the host register block and one sdfilter instance.

---
 rtl/sdfilter_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sdfilter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdfilter_ctrl
//  Description : Measurement sequencer for one sdfilter coincidence chain.
//                Applies gate0/gaten masks under filter reset, waits for the
//                delay lines to settle, counts pulses on one filter output
//                over a programmable window and offers the count to the
//                readout logic through a valid/ack handshake.
//                Optional gaten sweep (16 steps) when SDFILTER_CTRL_SCAN_EN
//                is defined; the default build performs a single run.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdfilter_ctrl #(
   parameter int FLUSH_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 18,
   parameter int WIN_W         = 24,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       cfg_gate0,
   input  logic [15:0]       cfg_gaten,
   input  logic [WIN_W-1:0]  cfg_window,
   input  logic [3:0]        cfg_chan,
   input  logic              start,
   output logic              busy,
   output logic              flt_reset,
   output logic [15:0]       flt_gate0,
   output logic [15:0]       flt_gaten,
   input  logic [15:0]       flt_out,
   output logic              res_valid,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf,
   output logic [3:0]        res_step,
   input  logic              res_ack
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FLUSH   = 3'd1,
      S_SETTLE  = 3'd2,
      S_MEASURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // FLUSH spans FLUSH_CYCLES+1 state cycles: the first one is the cycle in
   // which the freshly registered masks reach the filter, followed by the
   // full flush period with those masks applied.
   localparam logic [WIN_W-1:0] c_FLUSH_LAST  = WIN_W'(FLUSH_CYCLES);
   localparam logic [WIN_W-1:0] c_SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
   localparam logic [WIN_W-1:0] c_WIN_ONE     = WIN_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_timer_clr;
   logic              w_last_step;

   logic [WIN_W-1:0]  r_timer;
   logic [WIN_W-1:0]  r_window;
   logic [3:0]        r_chan;
   logic [15:0]       r_gate0;
   logic [15:0]       r_gaten;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;
   logic              r_busy;
   logic              r_flt_reset;
   logic              r_res_valid;

`ifdef SDFILTER_CTRL_SCAN_EN
   logic [3:0]        r_step;
   assign w_last_step = (r_step == 4'd15);
   assign res_step    = r_step;
`else
   assign w_last_step = 1'b1;
   assign res_step    = 4'd0;
`endif

   assign busy      = r_busy;
   assign flt_reset = r_flt_reset;
   assign flt_gate0 = r_gate0;
   assign flt_gaten = r_gaten;
   assign res_valid = r_res_valid;
   assign res_count = r_count;
   assign res_ovf   = r_ovf;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; the phase timer is cleared on every phase change.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_clr = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_FLUSH;
               w_timer_clr = 1'b1;
            end
         end
         S_FLUSH: begin
            if (r_timer == c_FLUSH_LAST) begin
               w_state_nxt = S_SETTLE;
               w_timer_clr = 1'b1;
            end
         end
         S_SETTLE: begin
            if (r_timer == c_SETTLE_LAST) begin
               w_state_nxt = (r_window == '0) ? S_DONE : S_MEASURE;
               w_timer_clr = 1'b1;
            end
         end
         S_MEASURE: begin
            if (r_timer == (r_window - c_WIN_ONE)) begin
               w_state_nxt = S_DONE;
               w_timer_clr = 1'b1;
            end
         end
         S_DONE: begin
            if (res_ack) begin
               w_state_nxt = w_last_step ? S_IDLE : S_FLUSH;
               w_timer_clr = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_timer_clr = 1'b1;
         end
      endcase
   end

   // Phase timer: runs during FLUSH, SETTLE and MEASURE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_timer <= '0;
      end else if (w_timer_clr) begin
         r_timer <= '0;
      end else if (r_state == S_FLUSH || r_state == S_SETTLE || r_state == S_MEASURE) begin
         r_timer <= r_timer + c_WIN_ONE;
      end
   end

   // Status outputs registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy      <= 1'b0;
         r_flt_reset <= 1'b1;
         r_res_valid <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt != S_IDLE);
         r_flt_reset <= !(w_state_nxt == S_SETTLE || w_state_nxt == S_MEASURE);
         r_res_valid <= (w_state_nxt == S_DONE);
      end
   end

   // Shadow configuration, scan stepping and the saturating event counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_window <= '0;
         r_chan   <= 4'd0;
         r_gate0  <= 16'd0;
         r_gaten  <= 16'd0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
`ifdef SDFILTER_CTRL_SCAN_EN
         r_step   <= 4'd0;
`endif
      end else begin
         if (r_state == S_IDLE && start) begin
            r_window <= cfg_window;
            r_chan   <= cfg_chan;
            r_gate0  <= cfg_gate0;
            r_gaten  <= cfg_gaten;
            r_count  <= '0;
            r_ovf    <= 1'b0;
`ifdef SDFILTER_CTRL_SCAN_EN
            r_step   <= 4'd0;
`endif
         end
`ifdef SDFILTER_CTRL_SCAN_EN
         else if (r_state == S_DONE && res_ack && !w_last_step) begin
            // Widen the gaten window by one tap for the next step.
            r_gaten  <= {r_gaten[14:0], 1'b1};
            r_step   <= r_step + 4'd1;
            r_count  <= '0;
            r_ovf    <= 1'b0;
         end
`endif
         else if (r_state == S_MEASURE && flt_out[r_chan]) begin
            if (r_count == c_CNT_MAX) begin
               r_ovf   <= 1'b1;
            end else begin
               r_count <= r_count + c_CNT_ONE;
            end
         end
      end
   end

endmodule
`default_nettype wire
